// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//   Sequences the instruction fetch stage. It drives the PC write enable, the
//   PC source selects, the IF/ID write enable and the pipeline flushes. It
//   arbitrates, in priority order, between halt, branch redirects resolved in
//   MEM, and load-use stalls. It also holds the PC for a fixed number of
//   cycles after reset is released.
//
//   Optional build macro: FETCH_STATS_EN adds three saturating 32-bit event
//   counters (o_redirect_cnt, o_stall_cnt, o_fetch_cnt).
//
// Parameters
//   BOOT_CYCLES   cycles the PC is held after reset release (1..255)
//   FLUSH_CYCLES  cycles after a redirect in which redirects and stalls
//                 are ignored (1..255)
//   STALL_MAX     consecutive stall cycles that raise o_stall_err (1..65535)
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_run_en         permits leaving BOOT once the boot count has expired
//   i_halt_req       halt instruction detected
//   i_stall_req      load-use hazard
//   i_br_cond_taken  PC-relative branch taken
//   i_br_reg         register branch taken
//   o_pc_write       1 = load new PC
//   o_pc_sel_add     select branch-adder target
//   o_pc_sel_reg     select register target
//   o_ifid_write     IF/ID enable
//   o_flush_ifid     squash IF/ID
//   o_flush_idex     squash ID/EX
//   o_flush_exmem    squash EX/MEM
//   o_halted         controller is in HALT
//   o_stall_err      sticky stall-watchdog error
//   o_fsm_state      BOOT=0 RUN=1 STALL=2 FLUSH=3 HALT=4
//
// States
//   BOOT  | PC held after reset, waiting for the boot count and i_run_en
//   RUN   | normal fetch
//   STALL | previous cycle was a load-use stall
//   FLUSH | redirect in flight; redirects and stalls ignored
//   HALT  | fetching stopped until reset
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_MAX    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run_en,
    input  logic        i_halt_req,
    input  logic        i_stall_req,
    input  logic        i_br_cond_taken,
    input  logic        i_br_reg,
    output logic        o_pc_write,
    output logic        o_pc_sel_add,
    output logic        o_pc_sel_reg,
    output logic        o_ifid_write,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic        o_flush_exmem,
    output logic        o_halted,
    output logic        o_stall_err,
`ifdef FETCH_STATS_EN
    output logic [31:0] o_redirect_cnt,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_fetch_cnt,
`endif
    output logic [2:0]  o_fsm_state
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [7:0]  BOOT_LAST  = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0]  FLUSH_LOAD = 8'(FLUSH_CYCLES);
    localparam logic [15:0] STALL_LIM  = 16'(STALL_MAX);

    state_t      r_state;
    logic [7:0]  r_boot_cnt;
    logic [7:0]  r_flush_cnt;
    logic [15:0] r_stall_run;
    logic        r_stall_err;

    logic        w_active;
    logic        w_take_halt;
    logic        w_take_redirect;
    logic        w_take_stall;
    logic [15:0] w_stall_run_inc;

    // Arbitration: halt > redirect > stall > normal. FLUSH only honours halt.
    assign w_active        = (r_state == ST_RUN) || (r_state == ST_STALL);
    assign w_take_halt     = (w_active || (r_state == ST_FLUSH)) && i_halt_req;
    assign w_take_redirect = w_active && !i_halt_req && (i_br_cond_taken || i_br_reg);
    assign w_take_stall    = w_active && !i_halt_req && !(i_br_cond_taken || i_br_reg)
                             && i_stall_req;
    assign w_stall_run_inc = (r_stall_run == 16'hFFFF) ? r_stall_run : r_stall_run + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= 8'd0;
            r_flush_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // Boot count saturates at its last value; then only i_run_en gates exit.
                    if (r_boot_cnt >= BOOT_LAST) begin
                        if (i_run_en) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 8'd1;
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (w_take_halt) begin
                        r_state <= ST_HALT;
                    end else if (w_take_redirect) begin
                        r_flush_cnt <= FLUSH_LOAD;
                        r_state     <= ST_FLUSH;
                    end else if (w_take_stall) begin
                        r_state <= ST_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (w_take_halt) begin
                        r_state <= ST_HALT;
                    end else if (r_flush_cnt <= 8'd1) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 8'd1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // Consecutive-stall watchdog: any non-stall cycle breaks the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_run <= 16'd0;
            r_stall_err <= 1'b0;
        end else begin
            if (w_take_stall) begin
                r_stall_run <= w_stall_run_inc;
                if (w_stall_run_inc >= STALL_LIM) begin
                    r_stall_err <= 1'b1;
                end
            end else begin
                r_stall_run <= 16'd0;
            end
        end
    end

    always_comb begin
        o_pc_write    = 1'b0;
        o_pc_sel_add  = 1'b0;
        o_pc_sel_reg  = 1'b0;
        o_ifid_write  = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_flush_exmem = 1'b0;
        o_halted      = 1'b0;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (w_take_halt) begin
                    o_flush_ifid = 1'b1;
                end else if (w_take_redirect) begin
                    o_pc_write    = 1'b1;
                    o_pc_sel_reg  = i_br_reg;
                    o_pc_sel_add  = i_br_cond_taken && !i_br_reg;
                    o_ifid_write  = 1'b1;
                    o_flush_ifid  = 1'b1;
                    o_flush_idex  = 1'b1;
                    o_flush_exmem = 1'b1;
                end else if (w_take_stall) begin
                    o_flush_idex = 1'b1;
                end else begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (w_take_halt) begin
                    o_flush_ifid = 1'b1;
                end else begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                end
            end
            ST_HALT: begin
                o_flush_ifid = 1'b1;
                o_halted     = 1'b1;
            end
            default: begin
                o_flush_ifid  = 1'b1;
                o_flush_idex  = 1'b1;
                o_flush_exmem = 1'b1;
            end
        endcase
    end

    assign o_stall_err = r_stall_err;
    assign o_fsm_state = r_state;

`ifdef FETCH_STATS_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_cnt <= 32'd0;
            r_stall_cnt    <= 32'd0;
            r_fetch_cnt    <= 32'd0;
        end else begin
            if (w_take_redirect && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_take_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (o_pc_write && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign o_redirect_cnt = r_redirect_cnt;
    assign o_stall_cnt    = r_stall_cnt;
    assign o_fetch_cnt    = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_en = 1'b0;
    logic       halt_req = 1'b0;
    logic       stall_req = 1'b0;
    logic       br_cond_taken = 1'b0;
    logic       br_reg = 1'b0;
    logic       pc_write, pc_sel_add, pc_sel_reg, ifid_write;
    logic       flush_ifid, flush_idex, flush_exmem, halted, stall_err;
    logic [2:0] fsm_state;
`ifdef FETCH_STATS_EN
    logic [31:0] redirect_cnt, stall_cnt, fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] v;
        string       nm;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    fetch_controller #(
        .BOOT_CYCLES (2),
        .FLUSH_CYCLES(2),
        .STALL_MAX   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_run_en       (run_en),
        .i_halt_req     (halt_req),
        .i_stall_req    (stall_req),
        .i_br_cond_taken(br_cond_taken),
        .i_br_reg       (br_reg),
        .o_pc_write     (pc_write),
        .o_pc_sel_add   (pc_sel_add),
        .o_pc_sel_reg   (pc_sel_reg),
        .o_ifid_write   (ifid_write),
        .o_flush_ifid   (flush_ifid),
        .o_flush_idex   (flush_idex),
        .o_flush_exmem  (flush_exmem),
        .o_halted       (halted),
        .o_stall_err    (stall_err),
`ifdef FETCH_STATS_EN
        .o_redirect_cnt (redirect_cnt),
        .o_stall_cnt    (stall_cnt),
        .o_fetch_cnt    (fetch_cnt),
`endif
        .o_fsm_state    (fsm_state)
    );

    // Expected vector layout:
    // {pc_write, sel_add, sel_reg, ifid_write}_{flush ifid,idex,exmem}_{halted, stall_err}_{state}
    localparam logic [11:0] E_BOOT      = 12'b0000_111_00_000;
    localparam logic [11:0] E_RUN       = 12'b1001_000_00_001;
    localparam logic [11:0] E_RUN_ERR   = 12'b1001_000_01_001;
    localparam logic [11:0] E_REDIR_ADD = 12'b1101_111_00_001;
    localparam logic [11:0] E_REDIR_REG = 12'b1011_111_00_001;
    localparam logic [11:0] E_FLUSH     = 12'b1001_000_00_011;
    localparam logic [11:0] E_STALL_R   = 12'b0000_010_00_001;
    localparam logic [11:0] E_STALL_S   = 12'b0000_010_00_010;
    localparam logic [11:0] E_STALL_REL = 12'b1001_000_00_010;

    // Inputs vector: {rst_n, run_en, halt_req, stall_req, br_cond_taken, br_reg}
    task automatic step(input logic [5:0] in, input logic [11:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        {rst_n, run_en, halt_req, stall_req, br_cond_taken, br_reg} = in;
        x.v  = e;
        x.nm = nm;
        q.push_back(x);
    endtask

    // Monitor: outputs are combinational from state and inputs, so every
    // cycle presents a response; compare it mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [11:0] act;
            x   = q.pop_front();
            act = {pc_write, pc_sel_add, pc_sel_reg, ifid_write,
                   flush_ifid, flush_idex, flush_exmem, halted, stall_err, fsm_state};
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s: got %b_%b_%b_%b want %b_%b_%b_%b", x.nm,
                         act[11:8], act[7:5], act[4:3], act[2:0],
                         x.v[11:8], x.v[7:5], x.v[4:3], x.v[2:0]);
            end
        end
    end

    initial begin
        // Reset and boot
        step(6'b000000, E_BOOT, "reset");
        step(6'b010000, E_BOOT, "reset_hold");
        step(6'b110000, E_BOOT, "boot1");
        step(6'b110000, E_BOOT, "boot2");
        step(6'b110000, E_RUN,  "boot_to_run");

        // PC-relative redirect, register branch in shadow is ignored
        step(6'b110000, E_RUN,       "run_normal");
        step(6'b110010, E_REDIR_ADD, "redirect_add");
        step(6'b110001, E_FLUSH,     "flush_ign_br");
        step(6'b110000, E_FLUSH,     "flush_last");
        step(6'b110000, E_RUN,       "flush_to_run");

        // Three-cycle load-use stall
        step(6'b110100, E_STALL_R,   "stall1");
        step(6'b110100, E_STALL_S,   "stall2");
        step(6'b110100, E_STALL_S,   "stall3");
        step(6'b110000, E_STALL_REL, "stall_release");
`ifdef FETCH_STATS_EN
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
        checks++;
        if (redirect_cnt !== 32'd1) begin
            errors++;
            $display("FAIL redirect_cnt: got %0d want 1", redirect_cnt);
        end
`endif
        step(6'b110000, E_RUN, "stall_back_run");

        // Redirect beats stall; register branch beats adder target
        step(6'b110111, E_REDIR_REG, "redirect_prio");
        step(6'b110100, E_FLUSH,     "flush_ign_stall");
        step(6'b110000, E_FLUSH,     "flush_last2");
        step(6'b110000, E_RUN,       "flush_to_run2");

        // Stall watchdog with STALL_MAX=4: error visible from the 5th stall cycle
        for (int i = 0; i < 10; i++) begin
            logic [11:0] e;
            e = {4'b0000, 3'b010, 1'b0, (i >= 4) ? 1'b1 : 1'b0,
                 (i == 0) ? 3'd1 : 3'd2};
            step(6'b110100, e, $sformatf("watchdog_%0d", i));
        end
        step(6'b110000, 12'b1001_000_01_010, "stall_err_sticky");
        step(6'b110000, E_RUN_ERR,           "stall_err_run");

        // Halt during FLUSH, then reset mid-HALT
        step(6'b110010, 12'b1101_111_01_001, "redirect_err");
        step(6'b111000, 12'b0000_100_01_011, "halt_in_flush");
        step(6'b110000, 12'b0000_100_11_100, "halted");
        step(6'b110010, 12'b0000_100_11_100, "halt_ign_br");
        step(6'b010000, E_BOOT,              "reset_mid_halt");

        // BOOT waits for run_en after the boot count expires
        step(6'b100000, E_BOOT, "boot_wait1");
        step(6'b100000, E_BOOT, "boot_wait2");
        step(6'b100000, E_BOOT, "boot_wait3");
        step(6'b110000, E_BOOT, "boot_go");
        step(6'b110000, E_RUN,  "boot_run_late");

        // Halt beats redirect in RUN
        step(6'b111010, 12'b0000_100_00_001, "halt_prio");
        step(6'b110000, 12'b0000_100_10_100, "halted2");

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
